// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the traffic phase sequencer and the display drivers
// that decode its phase output.
package traffic_pkg;

    localparam logic [2:0] PH_NS_GREEN  = 3'd0;
    localparam logic [2:0] PH_NS_YELLOW = 3'd1;
    localparam logic [2:0] PH_ALLRED_A  = 3'd2;
    localparam logic [2:0] PH_EW_GREEN  = 3'd3;
    localparam logic [2:0] PH_EW_YELLOW = 3'd4;
    localparam logic [2:0] PH_ALLRED_B  = 3'd5;
    localparam logic [2:0] PH_PED_WALK  = 3'd6;

    typedef enum logic [2:0] {
        NS_GREEN  = PH_NS_GREEN,
        NS_YELLOW = PH_NS_YELLOW,
        ALLRED_A  = PH_ALLRED_A,
        EW_GREEN  = PH_EW_GREEN,
        EW_YELLOW = PH_EW_YELLOW,
        ALLRED_B  = PH_ALLRED_B,
        PED_WALK  = PH_PED_WALK
    } state_e;

    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic logic [2:0] lamp(input int pos);
        return 3'b001 << pos;
    endfunction

    // {ns_light, ew_light}; whichever road is not green or yellow shows red.
    function automatic logic [5:0] lights_of(input state_e s);
        case (s)
            NS_GREEN:  return {lamp(GRN), lamp(RED)};
            NS_YELLOW: return {lamp(YEL), lamp(RED)};
            EW_GREEN:  return {lamp(RED), lamp(GRN)};
            EW_YELLOW: return {lamp(RED), lamp(YEL)};
            default:   return {lamp(RED), lamp(RED)};
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Tick/pedestrian inputs and light/status outputs of the phase sequencer.
interface traffic_phase_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             tick;
    logic             ped_req;
    logic             ped_ack;
    logic             walk;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;

    modport master (
        output tick, ped_req,
        input  ped_ack, walk, ns_light, ew_light, phase, remaining
    );

    modport slave (
        input  tick, ped_req,
        output ped_ack, walk, ns_light, ew_light, phase, remaining
    );
endinterface

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Tick counter for the current phase; done flags the tick that ends a phase
// of length dur. clear restarts counting on phase entry.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W:0]   dur,
    output logic [CNT_W-1:0] elapsed,
    output logic             done
);

    logic [CNT_W-1:0] elapsed_q;
    logic [CNT_W-1:0] elapsed_d;

    // Next count: restart on phase entry, advance on a tick, else hold.
    always_comb begin
        if (clear) begin
            elapsed_d = '0;
        end else if (tick) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end else begin
            elapsed_d = elapsed_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed = elapsed_q;
    assign done    = tick && ({1'b0, elapsed_q} == (dur - (CNT_W + 1)'(1)));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road light sequencer with a pedestrian walk phase inserted after an
// all-red clearance when a request is pending. All timing is in ticks.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter int GREEN_TICKS     = 10,
    parameter int MIN_GREEN_TICKS = 4,
    parameter int YELLOW_TICKS    = 3,
    parameter int ALLRED_TICKS    = 1,
    parameter int WALK_TICKS      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_phase_sequencer_if.slave bus
);

    localparam int DW      = CNT_W + 1;
    localparam int MAX_DUR = 2 ** CNT_W;

    if (GREEN_TICKS < 1 || GREEN_TICKS > MAX_DUR ||
        MIN_GREEN_TICKS < 1 || MIN_GREEN_TICKS > GREEN_TICKS ||
        YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_DUR ||
        ALLRED_TICKS < 1 || ALLRED_TICKS > MAX_DUR ||
        WALK_TICKS < 1 || WALK_TICKS > MAX_DUR) begin : g_bad_params
        $error("traffic_phase_sequencer: phase durations do not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_TICKS - 1);

    function automatic logic [DW-1:0] dur_of(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return DW'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: return DW'(YELLOW_TICKS);
            ALLRED_A, ALLRED_B:   return DW'(ALLRED_TICKS);
            PED_WALK:             return DW'(WALK_TICKS);
            default:              return DW'(GREEN_TICKS);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] last_of(input state_e s);
        return CNT_W'(dur_of(s) - DW'(1));
    endfunction

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             next_dir_q, next_dir_d;
    logic             ped_ack_q, ped_ack_d;
    logic             walk_q, walk_d;
    logic [5:0]       lights_q, lights_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [DW-1:0]    dur_s;
    logic [CNT_W-1:0] elapsed_s;
    logic             done_s;
    logic             is_green_s;
    logic             early_s;
    logic             advance_s;
    logic             enter_walk_s;

    assign dur_s      = dur_of(state_q);
    assign is_green_s = (state_q == NS_GREEN) || (state_q == EW_GREEN);
    // A pending pedestrian may cut a green short once the minimum has been served.
    assign early_s    = bus.tick && is_green_s && pending_q && (elapsed_s >= MIN_LAST);
    assign advance_s  = done_s || early_s;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (advance_s),
        .tick    (bus.tick),
        .dur     (dur_s),
        .elapsed (elapsed_s),
        .done    (done_s)
    );

    // Phase sequencing; next_dir remembers which road follows a walk.
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        if (advance_s) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: begin
                    state_d    = ALLRED_A;
                    next_dir_d = DIR_EW;
                end
                ALLRED_A:  state_d = pending_q ? PED_WALK : EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: begin
                    state_d    = ALLRED_B;
                    next_dir_d = DIR_NS;
                end
                ALLRED_B:  state_d = pending_q ? PED_WALK : NS_GREEN;
                PED_WALK:  state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
                default:   state_d = NS_GREEN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign enter_walk_s = advance_s && (state_d == PED_WALK);

    // Request latch: entering the walk consumes it, requests during the walk are dropped.
    always_comb begin
        if (enter_walk_s) begin
            pending_d = 1'b0;
        end else if (bus.ped_req && (state_q != PED_WALK)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Output values for the coming phase, so all outputs leave flops.
    always_comb begin
        ped_ack_d = enter_walk_s;
        walk_d    = (state_d == PED_WALK);
        lights_d  = lights_of(state_d);
        if (advance_s) begin
            remaining_d = last_of(state_d);
        end else if (bus.tick) begin
            remaining_d = remaining_q - CNT_W'(1);
        end else begin
            remaining_d = remaining_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= NS_GREEN;
            pending_q   <= 1'b0;
            next_dir_q  <= DIR_EW;
            ped_ack_q   <= 1'b0;
            walk_q      <= 1'b0;
            lights_q    <= lights_of(NS_GREEN);
            remaining_q <= last_of(NS_GREEN);
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            next_dir_q  <= next_dir_d;
            ped_ack_q   <= ped_ack_d;
            walk_q      <= walk_d;
            lights_q    <= lights_d;
            remaining_q <= remaining_d;
        end
    end

    assign bus.phase     = state_q;
    assign bus.ped_ack   = ped_ack_q;
    assign bus.walk      = walk_q;
    assign bus.ns_light  = lights_q[5:3];
    assign bus.ew_light  = lights_q[2:0];
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: a ring-of-phases reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_traffic_phase_sequencer;

    localparam int G    = 10;
    localparam int MING = 4;
    localparam int Y    = 3;
    localparam int AR   = 1;
    localparam int W    = 5;

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer_if #(.CNT_W(8)) bus_if ();

    traffic_phase_sequencer dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    // Reference model: position on the six-phase road ring plus a walk flag.
    int m_pos;
    bit m_walk;
    int m_ticks;
    bit m_pend;
    bit m_ack;

    function automatic int mdur(input int ph);
        int tab[7] = '{G, Y, AR, G, Y, AR, W};
        return tab[ph];
    endfunction

    function automatic int m_phase();
        return m_walk ? 6 : m_pos;
    endfunction

    function automatic int m_ns(input int ph);
        return (ph == 0) ? 1 : (ph == 1) ? 2 : 4;
    endfunction

    function automatic int m_ew(input int ph);
        return (ph == 3) ? 1 : (ph == 4) ? 2 : 4;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_walk = 0; m_ticks = 0; m_pend = 0; m_ack = 0;
    endtask

    task automatic model_update(input bit t, input bit p);
        bit was_walk;
        bit entered;
        bit green;
        bit leave;
        bit clearance;
        was_walk = m_walk;
        entered  = 0;
        m_ack    = 0;
        if (t) begin
            green = !m_walk && (m_pos == 0 || m_pos == 3);
            leave = (m_ticks == mdur(m_phase()) - 1) || (green && m_pend && m_ticks >= MING - 1);
            if (leave) begin
                m_ticks = 0;
                if (m_walk) begin
                    m_walk = 0;
                end else begin
                    clearance = (m_pos == 2 || m_pos == 5);
                    m_pos = (m_pos + 1) % 6;
                    if (clearance && m_pend) begin
                        m_walk = 1; m_pend = 0; m_ack = 1; entered = 1;
                    end
                end
            end else begin
                m_ticks++;
            end
        end
        if (p && !was_walk && !entered) m_pend = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("m_phase", int'(bus_if.phase), m_phase());
            chk("m_remaining", int'(bus_if.remaining), mdur(m_phase()) - 1 - m_ticks);
            chk("m_ns_light", int'(bus_if.ns_light), m_ns(m_phase()));
            chk("m_ew_light", int'(bus_if.ew_light), m_ew(m_phase()));
            chk("m_walk", int'(bus_if.walk), int'(m_walk));
            chk("m_ped_ack", int'(bus_if.ped_ack), int'(m_ack));
        end
    end

    task automatic step(input bit t, input bit p);
        bus_if.tick    = t;
        bus_if.ped_req = p;
        @(posedge clk);
        model_update(t, p);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit t, input bit p);
        for (int i = 0; i < n; i++) step(t, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.tick = 1'b0;
        bus_if.ped_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int n_ack;
    int n_walk;
    int n_green;

    initial begin
        rst_n = 1'b0;
        bus_if.tick = 1'b0;
        bus_if.ped_req = 1'b0;
        model_reset();

        // 1: plain road cycle after reset.
        do_reset();
        chk_en = 1'b1;
        chk("rst_phase", int'(bus_if.phase), 0);
        chk("rst_remaining", int'(bus_if.remaining), 9);
        chk("rst_ns", int'(bus_if.ns_light), 1);
        chk("rst_ew", int'(bus_if.ew_light), 4);
        chk("rst_walk", int'(bus_if.walk), 0);
        chk("rst_ack", int'(bus_if.ped_ack), 0);
        for (int k = 1; k <= 28; k++) begin
            step(1'b1, 1'b0);
            if (k == 1)  chk("t1_rem_step1", int'(bus_if.remaining), 8);
            if (k == 10) chk("t1_ns_yellow", int'(bus_if.phase), 1);
            if (k == 13) chk("t1_allred_a", int'(bus_if.phase), 2);
            if (k == 14) chk("t1_ew_green_rem", int'(bus_if.remaining), 9);
            if (k == 24) chk("t1_ew_yellow", int'(bus_if.phase), 4);
            if (k == 27) chk("t1_allred_b", int'(bus_if.phase), 5);
        end
        chk("t1_back_ns", int'(bus_if.phase), 0);
        chk("t1_back_rem", int'(bus_if.remaining), 9);

        // 2: early request cuts green after the minimum.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        run(2, 1'b1, 1'b0);
        chk("t2_cut_green", int'(bus_if.phase), 1);
        run(3, 1'b1, 1'b0);
        chk("t2_allred_a", int'(bus_if.phase), 2);
        step(1'b1, 1'b0);
        chk("t2_walk_phase", int'(bus_if.phase), 6);
        chk("t2_ack_first", int'(bus_if.ped_ack), 1);
        chk("t2_walk_first", int'(bus_if.walk), 1);
        step(1'b1, 1'b0);
        chk("t2_ack_second", int'(bus_if.ped_ack), 0);
        chk("t2_walk_second", int'(bus_if.walk), 1);
        run(4, 1'b1, 1'b0);
        chk("t2_ew_green", int'(bus_if.phase), 3);
        chk("t2_walk_done", int'(bus_if.walk), 0);

        // 3: late request does not shorten green.
        do_reset();
        run(8, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("t3_last_tick", int'(bus_if.remaining), 0);
        step(1'b1, 1'b0);
        chk("t3_full_green", int'(bus_if.phase), 1);
        run(3, 1'b1, 1'b0);
        chk("t3_allred_a", int'(bus_if.phase), 2);
        step(1'b1, 1'b0);
        chk("t3_walk", int'(bus_if.phase), 6);
        run(5, 1'b1, 1'b0);
        chk("t3_ew_green", int'(bus_if.phase), 3);

        // 4: ticks frozen mid EW_GREEN while a request arrives.
        do_reset();
        run(16, 1'b1, 1'b0);
        chk("t4_pre_phase", int'(bus_if.phase), 3);
        chk("t4_pre_rem", int'(bus_if.remaining), 7);
        run(10, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(39, 1'b0, 1'b0);
        chk("t4_frozen_phase", int'(bus_if.phase), 3);
        chk("t4_frozen_rem", int'(bus_if.remaining), 7);
        step(1'b1, 1'b0);
        chk("t4_resume_rem", int'(bus_if.remaining), 6);
        step(1'b1, 1'b0);
        chk("t4_cut", int'(bus_if.phase), 4);
        chk("t4_yel_rem", int'(bus_if.remaining), 2);

        // 5: asynchronous reset during EW_YELLOW with a request pending.
        do_reset();
        run(24, 1'b1, 1'b0);
        chk("t5_ew_yellow", int'(bus_if.phase), 4);
        step(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_phase", int'(bus_if.phase), 0);
        chk("t5_async_rem", int'(bus_if.remaining), 9);
        chk("t5_async_ns", int'(bus_if.ns_light), 1);
        chk("t5_async_ew", int'(bus_if.ew_light), 4);
        chk("t5_async_ack", int'(bus_if.ped_ack), 0);
        chk("t5_async_walk", int'(bus_if.walk), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("t5_no_walk", int'(bus_if.walk), 0);
        chk("t5_still_green", int'(bus_if.phase), 0);
        run(13, 1'b1, 1'b0);
        chk("t5_full_cycle", int'(bus_if.phase), 3);

        // 6: request held high throughout.
        do_reset();
        n_ack = 0; n_walk = 0; n_green = 0;
        for (int k = 0; k < 78; k++) begin
            step(1'b1, 1'b1);
            if (bus_if.ped_ack) n_ack++;
            if (bus_if.walk) n_walk++;
            if (bus_if.phase == 3'd0 || bus_if.phase == 3'd3) n_green++;
        end
        chk("t6_acks", n_ack, 6);
        chk("t6_walk_cycles", n_walk, 30);
        chk("t6_green_cycles", n_green, 24);
        chk("t6_end_phase", int'(bus_if.phase), 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
